spi_wrapper: RTL and testbench
==============================

SPI_WRAPPER -- requirements
Module: spi_wrapper

Interface
REQ-001 Parameter MEM_DEPTH, default 256: number of memory words.
REQ-002 Parameter ADDR_SIZE, default 8: address width in bits.
REQ-003 Parameter FRAME_WIDTH, default 8: data word and payload width in bits.
REQ-004 Port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port SS_n, input, 1: slave select, active-low; low frames a transaction.
REQ-007 Port MOSI, input, 1: serial data in, MSB first, sampled on the rising edge of clk.
REQ-008 Port MISO, output, 1: serial read data out, MSB first, registered.

Function
REQ-009 The slave FSM SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD and READ_DATA.
REQ-010 In IDLE, SS_n low SHALL cause a move to CHK_CMD at the next edge.
REQ-011 In CHK_CMD, the move SHALL depend on MOSI, which is frame bit 10:
- MOSI=0 -> WRITE.
- MOSI=1 with rd_addr_flag=0 -> READ_ADD.
- MOSI=1 with rd_addr_flag=1 -> READ_DATA.
REQ-012 In WRITE, READ_ADD and READ_DATA, the slave SHALL shift 10 MOSI bits MSB-first into rx_data[9:0] (frame bits 9..0), then pulse rx_valid for 1 cycle on the edge that captures bit 0.
REQ-013 The command SHALL be rx_data[9:8], and the payload SHALL be rx_data[7:0].
REQ-014 RAM actions, taken on the edge after rx_valid:
- 00 -> wr_addr <= payload.
- 01 -> mem[wr_addr] <= payload.
- 10 -> rd_addr <= payload.
- 11 -> dout <= mem[rd_addr] and tx_valid <= 1 (payload ignored, may be X).
REQ-015 Leaving READ_ADD SHALL set rd_addr_flag, and leaving READ_DATA SHALL clear it.
REQ-016 Read timing: if bit 0 is captured at edge N, then:
- tx_valid is 1 at edge N+1.
- MISO = dout[7] from edge N+2.
- One further bit is presented per edge until dout[0], which is then held.
REQ-017 MISO SHALL be 0 at all times other than while serialising dout.
REQ-018 SS_n high in any non-IDLE state SHALL return the FSM to IDLE at the next edge, aborting the frame: counters are cleared and no rx_valid is generated.
REQ-019 Addresses SHALL wrap modulo MEM_DEPTH; no bounds error is raised.
REQ-020 Memory contents SHALL be held in array mem, with depth MEM_DEPTH and width FRAME_WIDTH, inside instance ram_inst, and SHALL be preloadable by the bench through the hierarchical path ram_inst.mem.

Reset
REQ-021 rst_n low SHALL immediately force the following: state=IDLE, MISO=0, rx_data=0, rx_valid=0, tx_valid=0, dout=0, wr_addr=0, rd_addr=0, rd_addr_flag=0, and all counters=0.
REQ-022 Memory contents SHALL NOT be reset.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no memory write.

Configuration
REQ-024 With macro SPI_WRAPPER_ASSERT_EN defined, the block SHALL compile concurrent assertions for three properties:
- The state is always legal.
- rx_valid is never high for 2 consecutive cycles.
- MISO is 0 whenever SS_n is high.
REQ-025 Without SPI_WRAPPER_ASSERT_EN, no assertion code SHALL be compiled, and behaviour SHALL be identical.

Structure
REQ-026 Package spi_pkg SHALL hold the FSM state enum, the 2-bit command codes (00, 01, 10, 11) and the rx frame width constant (FRAME_WIDTH+2).
REQ-027 The RAM SHALL be the one sub-module, spi_ram, instantiated as ram_inst.
REQ-028 The slave FSM and shift logic SHALL be inline in spi_wrapper.

Verification
REQ-029 Write then read: frames 000_0x24, 001_0x81, 110_0x24, then 111_X -> MISO bits 1,0,0,0,0,0,0,1 appear starting 2 cycles after the last MOSI bit.
REQ-030 Preloaded read: mem[0x10]=0x5A via ram_inst.mem, then 110_0x10 and 111_X -> received byte 0x5A, with memory unchanged.
REQ-031 Abort: SS_n raised after 5 bits of 001_0xFF -> mem[wr_addr] unchanged, FSM back in IDLE next edge, and the next full frame decodes correctly.
REQ-032 Flag alternation: two consecutive 110 frames with no 111 between -> the second is treated as READ_DATA (tx_valid=1, MISO driven).
REQ-033 Async reset: rst_n pulsed low mid read-out -> MISO=0 and state=IDLE immediately, and a following 110/111 pair returns the correct data.
REQ-034 Random regression: 100 iterations of random addr/data write then read -> read data equals ram_inst.mem[addr] in every case.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave wrapper: FSM states, the 2-bit
// command codes and the received-frame width.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  localparam int FRAME_WIDTH_DEF = 8;
  localparam int RX_FRAME_W      = FRAME_WIDTH_DEF + CMD_W;

  // rx frame = command bits followed by one payload word
  function automatic int rx_frame_w(input int frame_width);
    return frame_width + CMD_W;
  endfunction

endpackage

// File: rtl/spi_ram.sv
// Single-port command-driven RAM behind the SPI slave: holds the write/read
// address registers, the memory array and the read-data register.
module spi_ram
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int ADDR_SIZE   = 8,
  parameter int FRAME_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  cmd_t                   cmd,
  input  logic [FRAME_WIDTH-1:0] payload,
  output logic [FRAME_WIDTH-1:0] dout,
  output logic                   tx_valid
);

  logic [FRAME_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
  logic [FRAME_WIDTH-1:0] dout_q, dout_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [ADDR_SIZE-1:0]   pl_addr;

  // Addresses wrap modulo the depth so every stored address indexes mem.
  assign pl_addr = ADDR_SIZE'(32'(payload) % 32'(MEM_DEPTH));

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_d = pl_addr;
        CMD_RD_ADDR: rd_addr_d = pl_addr;
        CMD_RD_DATA: begin
          dout_d     = mem[rd_addr_q];
          tx_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (rx_valid && (cmd == CMD_WR_DATA)) begin
      mem[wr_addr_q] <= payload;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: rtl/spi_wrapper.sv
// SPI slave front end (frame FSM, MOSI shifter, MISO serialiser) around spi_ram.
// Define SPI_WRAPPER_ASSERT_EN to compile the built-in concurrent assertions.
module spi_wrapper
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int ADDR_SIZE   = 8,
  parameter int FRAME_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int RX_W      = rx_frame_w(FRAME_WIDTH);
  localparam int BIT_CNT_W = $clog2(RX_W + 1);
  localparam int TX_CNT_W  = $clog2(FRAME_WIDTH + 1);

  state_t                 state_q, state_d;
  logic [RX_W-1:0]        rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_rd_q, rx_rd_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   rd_addr_flag_q, rd_addr_flag_d;
  logic                   miso_q, miso_d;
  logic                   tx_busy_q, tx_busy_d;
  logic [TX_CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [FRAME_WIDTH-1:0] tx_shift_q, tx_shift_d;

  logic                   tx_valid;
  logic [FRAME_WIDTH-1:0] dout;
  cmd_t                   ram_cmd;

  // rx_valid and tx_valid are single-cycle strobes with no back-pressure:
  // the RAM acts on the edge after rx_valid, and the serialiser loads dout on
  // the edge after tx_valid.

  always_comb begin
    state_d        = state_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_rd_d        = rx_rd_q;
    bit_cnt_d      = bit_cnt_q;
    rd_addr_flag_d = rd_addr_flag_q;
    if (SS_n) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      if (state_q == READ_ADD)  rd_addr_flag_d = 1'b1;
      if (state_q == READ_DATA) rd_addr_flag_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CHK_CMD;
          bit_cnt_d = '0;
        end
        CHK_CMD: begin
          if (!MOSI)               state_d = WRITE;
          else if (!rd_addr_flag_q) state_d = READ_ADD;
          else                      state_d = READ_DATA;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt_q != BIT_CNT_W'(RX_W)) begin
            rx_data_d = {rx_data_q[RX_W-2:0], MOSI};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_CNT_W'(RX_W - 1)) begin
              rx_valid_d = 1'b1;
              rx_rd_d    = (state_q == READ_DATA);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A frame received in READ_DATA is always a data read, whatever its bit 8.
  assign ram_cmd = rx_rd_q ? CMD_RD_DATA : cmd_t'(rx_data_q[RX_W-1 -: CMD_W]);

  always_comb begin
    miso_d     = miso_q;
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    if (SS_n) begin
      miso_d    = 1'b0;
      tx_busy_d = 1'b0;
      tx_cnt_d  = '0;
    end else if (tx_valid) begin
      miso_d     = dout[FRAME_WIDTH-1];
      tx_shift_d = dout;
      tx_busy_d  = 1'b1;
      tx_cnt_d   = TX_CNT_W'(1);
    end else if (tx_busy_q && (tx_cnt_q != TX_CNT_W'(FRAME_WIDTH))) begin
      miso_d     = tx_shift_q[FRAME_WIDTH-2];
      tx_shift_d = tx_shift_q << 1;
      tx_cnt_d   = tx_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_rd_q        <= 1'b0;
      bit_cnt_q      <= '0;
      rd_addr_flag_q <= 1'b0;
      miso_q         <= 1'b0;
      tx_busy_q      <= 1'b0;
      tx_cnt_q       <= '0;
      tx_shift_q     <= '0;
    end else begin
      state_q        <= state_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_rd_q        <= rx_rd_d;
      bit_cnt_q      <= bit_cnt_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      miso_q         <= miso_d;
      tx_busy_q      <= tx_busy_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_shift_q     <= tx_shift_d;
    end
  end

  assign MISO = miso_q;

  spi_ram #(
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_SIZE  (ADDR_SIZE),
    .FRAME_WIDTH(FRAME_WIDTH)
  ) ram_inst (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_valid(rx_valid_q),
    .cmd     (ram_cmd),
    .payload (rx_data_q[FRAME_WIDTH-1:0]),
    .dout    (dout),
    .tx_valid(tx_valid)
  );

`ifdef SPI_WRAPPER_ASSERT_EN
  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    state_q inside {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA});
  a_rx_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    rx_valid_q |=> !rx_valid_q);
  // MISO is registered, so it goes quiet on the edge that samples SS_n high.
  a_miso_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    SS_n |=> !MISO);
`else
  // no assertion logic in this build
`endif

endmodule

// File: tb/tb_spi_wrapper.sv
// Self-checking bench for spi_wrapper: directed scenarios plus a randomized
// write/read regression against a frame-level reference model.
module tb_spi_wrapper;
  import spi_pkg::*;

  logic clk;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic MISO;

  int checks = 0;
  int errors = 0;

  // frame-level reference model
  logic [7:0] m_mem [256];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  bit         m_flag;

  spi_wrapper dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr   = 8'h00;
    m_rd   = 8'h00;
    m_flag = 1'b0;
  endtask

  // Effect of one complete 11-bit frame on the model.
  task automatic model_frame(input logic [10:0] f, output bit is_rd, output logic [7:0] exp);
    logic [1:0] cmd;
    logic [7:0] pl;
    cmd   = f[9:8];
    pl    = f[7:0];
    is_rd = 1'b0;
    exp   = 8'h00;
    if (f[10]) begin
      if (m_flag) begin
        cmd    = 2'b11;
        m_flag = 1'b0;
      end else begin
        m_flag = 1'b1;
      end
    end
    case (cmd)
      2'b00: m_wr = pl;
      2'b01: m_mem[m_wr] = pl;
      2'b10: m_rd = pl;
      default: begin
        is_rd = 1'b1;
        exp   = m_mem[m_rd];
      end
    endcase
  endtask

  // driver: select, then nbits MOSI bits from bit 10 downwards
  task automatic start_frame(input logic [10:0] f, input int nbits);
    SS_n = 1'b0;
    MOSI = 1'b0;
    wait_edge();
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[10-i];
      wait_edge();
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    bit         is_rd;
    logic [7:0] exp;
    logic [7:0] got;
    model_frame(f, is_rd, exp);
    start_frame(f, 11);
    if (!is_rd) SS_n = 1'b1;
    wait_edge();
    checks++;
    if (dut.tx_valid !== is_rd) begin
      errors++;
      $display("FAIL tx_valid frame=%h got=%b want=%b", f, dut.tx_valid, is_rd);
    end
    if (is_rd) begin
      got = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        wait_edge();
        got[i] = MISO;
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL read_byte frame=%h got=%h want=%h", f, got, exp);
      end
      wait_edge();
      checks++;
      if (MISO !== exp[0]) begin
        errors++;
        $display("FAIL miso_hold frame=%h got=%b want=%b", f, MISO, exp[0]);
      end
      SS_n = 1'b1;
      wait_edge();
    end
    checks++;
    if (MISO !== 1'b0) begin
      errors++;
      $display("FAIL miso_idle frame=%h got=%b want=0", f, MISO);
    end
    wait_edge();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    wait_edge();
    wait_edge();
    checks++;
    if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b want=0", MISO); end
    checks++;
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, IDLE); end
    checks++;
    if (dut.ram_inst.wr_addr_q !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got=%h want=00", dut.ram_inst.wr_addr_q); end
    checks++;
    if (dut.ram_inst.rd_addr_q !== 8'h00) begin errors++; $display("FAIL reset_rd_addr got=%h want=00", dut.ram_inst.rd_addr_q); end
    checks++;
    if (dut.rd_addr_flag_q !== 1'b0) begin errors++; $display("FAIL reset_flag got=%b want=0", dut.rd_addr_flag_q); end
    checks++;
    if (dut.ram_inst.dout_q !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h want=00", dut.ram_inst.dout_q); end
    checks++;
    if (dut.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b want=0", dut.tx_valid); end
    for (int i = 0; i < 256; i++) begin
      dut.ram_inst.mem[i] = 8'h00;
      m_mem[i]            = 8'h00;
    end
    model_reset();
    rst_n = 1'b1;
    wait_edge();
  endtask

  task automatic test_write_read();
    send_frame({3'b000, 8'h24});
    send_frame({3'b001, 8'h81});
    checks++;
    if (dut.ram_inst.mem[8'h24] !== 8'h81) begin
      errors++;
      $display("FAIL write_mem got=%h want=81", dut.ram_inst.mem[8'h24]);
    end
    send_frame({3'b110, 8'h24});
    send_frame({3'b111, 8'($urandom_range(0, 255))});
  endtask

  task automatic test_preload();
    dut.ram_inst.mem[8'h10] = 8'h5A;
    m_mem[8'h10]            = 8'h5A;
    send_frame({3'b110, 8'h10});
    send_frame({3'b111, 8'($urandom_range(0, 255))});
    checks++;
    if (dut.ram_inst.mem[8'h10] !== 8'h5A) begin
      errors++;
      $display("FAIL preload_unchanged got=%h want=5a", dut.ram_inst.mem[8'h10]);
    end
  endtask

  task automatic test_abort();
    start_frame({3'b001, 8'hFF}, 5);
    SS_n = 1'b1;
    wait_edge();
    checks++;
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL abort_state got=%0d want=%0d", dut.state_q, IDLE); end
    checks++;
    if (dut.bit_cnt_q !== '0) begin errors++; $display("FAIL abort_bit_cnt got=%0d want=0", dut.bit_cnt_q); end
    wait_edge();
    wait_edge();
    checks++;
    if (dut.ram_inst.mem[m_wr] !== m_mem[m_wr]) begin
      errors++;
      $display("FAIL abort_mem addr=%h got=%h want=%h", m_wr, dut.ram_inst.mem[m_wr], m_mem[m_wr]);
    end
    send_frame({3'b000, 8'h33});
    send_frame({3'b001, 8'hC3});
    checks++;
    if (dut.ram_inst.mem[8'h33] !== 8'hC3) begin
      errors++;
      $display("FAIL abort_next_write got=%h want=c3", dut.ram_inst.mem[8'h33]);
    end
    send_frame({3'b110, 8'h33});
    send_frame({3'b111, 8'h00});
  endtask

  task automatic test_flag_alternation();
    send_frame({3'b110, 8'h33});
    send_frame({3'b110, 8'($urandom_range(0, 255))});
    checks++;
    if (dut.rd_addr_flag_q !== 1'b0) begin
      errors++;
      $display("FAIL flag_cleared got=%b want=0", dut.rd_addr_flag_q);
    end
  endtask

  task automatic test_async_reset();
    bit         is_rd;
    logic [7:0] exp;
    send_frame({3'b000, 8'h5C});
    send_frame({3'b001, 8'hFF});
    send_frame({3'b110, 8'h5C});
    model_frame({3'b111, 8'h00}, is_rd, exp);
    start_frame({3'b111, 8'h00}, 11);
    for (int i = 0; i < 4; i++) wait_edge();
    checks++;
    if (MISO !== 1'b1) begin errors++; $display("FAIL pre_reset_miso got=%b want=1", MISO); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (MISO !== 1'b0) begin errors++; $display("FAIL async_reset_miso got=%b want=0", MISO); end
    checks++;
    if (dut.state_q !== IDLE) begin errors++; $display("FAIL async_reset_state got=%0d want=%0d", dut.state_q, IDLE); end
    SS_n = 1'b1;
    MOSI = 1'b0;
    wait_edge();
    wait_edge();
    rst_n = 1'b1;
    model_reset();
    wait_edge();
    send_frame({3'b110, 8'h5C});
    send_frame({3'b111, 8'($urandom_range(0, 255))});
  endtask

  task automatic test_random();
    logic [7:0] addr;
    logic [7:0] data;
    for (int it = 0; it < 100; it++) begin
      addr = 8'($urandom_range(0, 255));
      data = 8'($urandom_range(0, 255));
      send_frame({3'b000, addr});
      send_frame({3'b001, data});
      send_frame({3'b110, addr});
      send_frame({3'b111, 8'($urandom_range(0, 255))});
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_preload();
    test_abort();
    test_flag_alternation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
